// File: rtl/complex_issue_sched.sv
// Issue scheduler for the 2-slot complex reservation station: oldest-ready arbitration,
// multi-cycle occupancy tracking and result hold until the ROB accepts it.
module complex_issue_sched #(
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_DIV = 16,
    parameter int unsigned LAT_ALU = 1,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [1:0] slot_valid,
    input  logic [1:0] slot_ready,
    input  logic [1:0] slot_alloc,
    input  logic [5:0] slot0_op,
    input  logic [5:0] slot1_op,
    input  logic       res_ready,
    output logic [1:0] issue_grant,
    output logic       selector,
    output logic       unit_busy,
    output logic       res_valid,
    output logic       res_slot
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mask_q, mask_d;
    logic             sel_q, sel_d;
    logic             res_slot_q, res_slot_d;
    logic             armed_q;

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             can_grant;
    logic [5:0]       grant_op;
    logic [CNT_W:0]   lat;
    logic [CNT_W:0]   lat_m2;

    assign elig = slot_valid & slot_ready & ~mask_q;

    // armed_q blocks grants in the first cycle after reset release
    assign can_grant = armed_q & ~flush &
                       ((state_q == StIdle) || ((state_q == StWb) && res_ready));

    always_comb begin
        grant = 2'b00;
        if (can_grant) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = sel_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_op = grant[1] ? slot1_op : slot0_op;

    always_comb begin
        case (grant_op[5:4])
            2'b10:   lat = (CNT_W+1)'(LAT_MUL);
            2'b11:   lat = (CNT_W+1)'(LAT_DIV);
            default: lat = (CNT_W+1)'(LAT_ALU);
        endcase
        lat_m2 = lat - (CNT_W+1)'(2);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_slot_d = res_slot_q;

        unique case (state_q)
            StIdle: ;
            StExec: begin
                if (cnt_q == '0) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWb: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A grant (from IDLE or the WB handshake) starts the next op
        if (grant != 2'b00) begin
            res_slot_d = grant[1];
            if (lat == (CNT_W+1)'(1)) begin
                state_d = StWb;
            end else begin
                state_d = StExec;
                cnt_d   = lat_m2[CNT_W-1:0];
            end
        end

        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (slot_alloc[i] || !slot_valid[i]) begin
                mask_d[i] = 1'b0;
            end else if (grant[i]) begin
                mask_d[i] = 1'b1;
            end else begin
                mask_d[i] = mask_q[i];
            end
        end
        if (flush) begin
            mask_d = 2'b00;
        end
    end

    always_comb begin
        case (slot_alloc)
            2'b01:   sel_d = 1'b0;
            2'b10:   sel_d = 1'b1;
            2'b11:   sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mask_q     <= 2'b00;
            sel_q      <= 1'b0;
            res_slot_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            sel_q      <= sel_d;
            res_slot_q <= res_slot_d;
            armed_q    <= 1'b1;
        end
    end

    assign issue_grant = grant;
    assign selector    = sel_q;
    assign unit_busy   = (state_q != StIdle);
    assign res_valid   = (state_q == StWb);
    assign res_slot    = res_slot_q;

endmodule

// File: tb/tb_complex_issue_sched.sv
// Directed bench for complex_issue_sched: arbitration, latency classes, WB hold,
// back-to-back issue, flush and asynchronous reset.
module tb_complex_issue_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] slot_valid = 2'b00;
    logic [1:0] slot_ready = 2'b00;
    logic [1:0] slot_alloc = 2'b00;
    logic [5:0] slot0_op = 6'h00;
    logic [5:0] slot1_op = 6'h00;
    logic       res_ready = 1'b0;
    logic [1:0] issue_grant;
    logic       selector;
    logic       unit_busy;
    logic       res_valid;
    logic       res_slot;

    int n_checks = 0;
    int n_fail   = 0;

    complex_issue_sched dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .slot_valid (slot_valid),
        .slot_ready (slot_ready),
        .slot_alloc (slot_alloc),
        .slot0_op   (slot0_op),
        .slot1_op   (slot1_op),
        .res_ready  (res_ready),
        .issue_grant(issue_grant),
        .selector   (selector),
        .unit_busy  (unit_busy),
        .res_valid  (res_valid),
        .res_slot   (res_slot)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        slot_valid = 2'b11;
        slot_ready = 2'b11;
        #1;
        n_checks++; if (issue_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", issue_grant); end
        n_checks++; if (unit_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", unit_busy); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_checks++; if (res_slot !== 1'b0) begin n_fail++; $display("FAIL reset_res_slot: got %b want 0", res_slot); end
        n_checks++; if (selector !== 1'b0) begin n_fail++; $display("FAIL reset_selector: got %b want 0", selector); end
        slot_valid = 2'b00;
        slot_ready = 2'b00;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_single();
        slot_valid = 2'b01; slot_ready = 2'b01; slot0_op = 6'h05;
        #2;
        n_checks++; if (issue_grant !== 2'b01) begin n_fail++; $display("FAIL alu_grant: got %b want 01", issue_grant); end
        tick();
        res_ready = 1'b1;
        #2;
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL alu_res_valid_t1: got %b want 1", res_valid); end
        n_checks++; if (res_slot !== 1'b0) begin n_fail++; $display("FAIL alu_res_slot: got %b want 0", res_slot); end
        n_checks++; if (issue_grant !== 2'b00) begin n_fail++; $display("FAIL alu_no_regrant: got %b want 00", issue_grant); end
        n_checks++; if (unit_busy !== 1'b1) begin n_fail++; $display("FAIL alu_busy_wb: got %b want 1", unit_busy); end
        tick();
        #2;
        n_checks++; if (unit_busy !== 1'b0) begin n_fail++; $display("FAIL alu_idle_after_ack: got %b want 0", unit_busy); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL alu_res_valid_drop: got %b want 0", res_valid); end
        n_checks++; if (issue_grant !== 2'b00) begin n_fail++; $display("FAIL alu_mask_holds: got %b want 00", issue_grant); end
        slot_valid = 2'b00; slot_ready = 2'b00; res_ready = 1'b0;
        tick();
    endtask

    task automatic test_selector();
        logic [1:0] allocs [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        logic       exp    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            slot_alloc = allocs[i];
            tick();
            slot_alloc = 2'b00;
            #2;
            n_checks++;
            if (selector !== exp[i]) begin
                n_fail++;
                $display("FAIL selector_alloc%0d: got %b want %b", i, selector, exp[i]);
            end
        end
    endtask

    task automatic test_oldest_first();
        slot_alloc = 2'b01;
        tick();
        slot_valid = 2'b01; slot_alloc = 2'b10;
        tick();
        slot_valid = 2'b11; slot_alloc = 2'b00; slot_ready = 2'b11;
        slot0_op = 6'h01; slot1_op = 6'h01;
        #2;
        n_checks++; if (selector !== 1'b1) begin n_fail++; $display("FAIL old_selector: got %b want 1", selector); end
        n_checks++; if (issue_grant !== 2'b01) begin n_fail++; $display("FAIL old_grant_first: got %b want 01", issue_grant); end
        tick();
        #2;
        n_checks++; if (issue_grant !== 2'b00) begin n_fail++; $display("FAIL old_wait_ack: got %b want 00", issue_grant); end
        n_checks++; if (res_slot !== 1'b0) begin n_fail++; $display("FAIL old_res_slot0: got %b want 0", res_slot); end
        tick();
        res_ready = 1'b1; slot_valid = 2'b10;
        #2;
        n_checks++; if (issue_grant !== 2'b10) begin n_fail++; $display("FAIL old_grant_second: got %b want 10", issue_grant); end
        tick();
        slot_valid = 2'b00;
        #2;
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL old_res_valid2: got %b want 1", res_valid); end
        n_checks++; if (res_slot !== 1'b1) begin n_fail++; $display("FAIL old_res_slot1: got %b want 1", res_slot); end
        tick();
        res_ready = 1'b0; slot_ready = 2'b00;
        #2;
        n_checks++; if (unit_busy !== 1'b0) begin n_fail++; $display("FAIL old_idle: got %b want 0", unit_busy); end
    endtask

    task automatic test_div_latency();
        int busy_cycles;
        busy_cycles = 0;
        slot_valid = 2'b11; slot_ready = 2'b01; slot0_op = 6'h30; slot1_op = 6'h01;
        #2;
        n_checks++; if (issue_grant !== 2'b01) begin n_fail++; $display("FAIL div_grant: got %b want 01", issue_grant); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 2) slot_ready = 2'b11;
            #2;
            if (unit_busy === 1'b1) busy_cycles++;
            n_checks++;
            if (issue_grant !== 2'b00) begin
                n_fail++; $display("FAIL div_blocked_k%0d: got %b want 00", k, issue_grant);
            end
            n_checks++;
            if (res_valid !== (k == 16)) begin
                n_fail++; $display("FAIL div_res_valid_k%0d: got %b want %b", k, res_valid, k == 16);
            end
        end
        n_checks++; if (busy_cycles != 16) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 16", busy_cycles); end
        res_ready = 1'b1; slot_valid = 2'b10;
        #2;
        n_checks++; if (issue_grant !== 2'b10) begin n_fail++; $display("FAIL div_b2b_grant: got %b want 10", issue_grant); end
        tick();
        slot_valid = 2'b00;
        #2;
        n_checks++; if (res_slot !== 1'b1) begin n_fail++; $display("FAIL div_next_slot: got %b want 1", res_slot); end
        tick();
        res_ready = 1'b0; slot_ready = 2'b00;
    endtask

    task automatic test_wb_hold();
        slot_valid = 2'b11; slot_ready = 2'b10; slot1_op = 6'h20; slot0_op = 6'h05;
        #2;
        n_checks++; if (issue_grant !== 2'b10) begin n_fail++; $display("FAIL hold_grant: got %b want 10", issue_grant); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) slot_ready = 2'b11;
            #2;
            n_checks++;
            if (res_valid !== (k == 3)) begin
                n_fail++; $display("FAIL mul_res_valid_k%0d: got %b want %b", k, res_valid, k == 3);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            #2;
            n_checks++;
            if ({res_valid, res_slot, issue_grant} !== 4'b1100) begin
                n_fail++;
                $display("FAIL hold_stable_k%0d: got valid=%b slot=%b grant=%b want 1 1 00",
                         k, res_valid, res_slot, issue_grant);
            end
        end
        res_ready = 1'b1; slot_valid = 2'b01;
        #2;
        n_checks++; if (issue_grant !== 2'b01) begin n_fail++; $display("FAIL hold_b2b_grant: got %b want 01", issue_grant); end
        tick();
        slot_valid = 2'b00;
        #2;
        n_checks++; if ({res_valid, res_slot} !== 2'b10) begin n_fail++; $display("FAIL hold_next_res: got %b%b want 10", res_valid, res_slot); end
        tick();
        res_ready = 1'b0; slot_ready = 2'b00;
    endtask

    task automatic test_flush();
        slot_valid = 2'b01; slot_ready = 2'b01; slot0_op = 6'h2A;
        #2;
        n_checks++; if (issue_grant !== 2'b01) begin n_fail++; $display("FAIL flush_grant: got %b want 01", issue_grant); end
        tick();
        tick();
        flush = 1'b1; slot_valid = 2'b11; slot_ready = 2'b11;
        #2;
        n_checks++; if (issue_grant !== 2'b00) begin n_fail++; $display("FAIL flush_blocks_grant: got %b want 00", issue_grant); end
        tick();
        flush = 1'b0; slot_valid = 2'b01; slot_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_checks++;
            if ({unit_busy, res_valid} !== 2'b00) begin
                n_fail++; $display("FAIL flush_idle_k%0d: got busy=%b valid=%b want 0 0", k, unit_busy, res_valid);
            end
            tick();
        end
        n_checks++; if (selector !== 1'b1) begin n_fail++; $display("FAIL flush_selector: got %b want 1", selector); end
        slot_ready = 2'b01;
        #2;
        n_checks++; if (issue_grant !== 2'b01) begin n_fail++; $display("FAIL flush_mask_cleared: got %b want 01", issue_grant); end
        tick(); tick(); tick();
        flush = 1'b1; res_ready = 1'b1; slot_valid = 2'b11; slot_ready = 2'b11;
        #2;
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL flush_wb_reached: got %b want 1", res_valid); end
        n_checks++; if (issue_grant !== 2'b00) begin n_fail++; $display("FAIL flush_dominates_ack: got %b want 00", issue_grant); end
        tick();
        flush = 1'b0; res_ready = 1'b0; slot_valid = 2'b00; slot_ready = 2'b00;
        #2;
        n_checks++; if ({unit_busy, res_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_drop_result: got %b%b want 00", unit_busy, res_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        slot_valid = 2'b10; slot_ready = 2'b10; slot1_op = 6'h30;
        #2;
        n_checks++; if (issue_grant !== 2'b10) begin n_fail++; $display("FAIL arst_grant: got %b want 10", issue_grant); end
        tick(); tick(); tick();
        n_checks++; if (unit_busy !== 1'b1) begin n_fail++; $display("FAIL arst_exec: got %b want 1", unit_busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({issue_grant, selector, unit_busy, res_valid, res_slot} !== 6'b000000) begin
            n_fail++;
            $display("FAIL arst_outputs: got grant=%b sel=%b busy=%b valid=%b slot=%b want all 0",
                     issue_grant, selector, unit_busy, res_valid, res_slot);
        end
        tick();
        rst = 1'b0;
        #2;
        n_checks++; if (issue_grant !== 2'b00) begin n_fail++; $display("FAIL arst_no_grant_after: got %b want 00", issue_grant); end
        tick();
        #1;
        n_checks++; if (issue_grant !== 2'b10) begin n_fail++; $display("FAIL arst_grant_resumes: got %b want 10", issue_grant); end
        rst = 1'b1;
        slot_valid = 2'b00; slot_ready = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_selector();
        test_oldest_first();
        test_div_latency();
        test_wb_hold();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
